exp_lane_scheduler: RTL and testbench

Round-robin scheduler that shares `NUM_LANES` sequential e^x lanes (Q7.8 in, Q0.16 out, one input in flight per lane, fixed multi-cycle latency) behind one AXI-Stream-style input and one output. It sits between the max-subtract stage and the sum/normalize stage of the softmax pipeline. It raises exp throughput by about `NUM_LANES`×. Output order equals input order, and `last` is preserved. Because each lane presents its result for exactly one cycle and cannot be back-pressured, the scheduler captures every result into a per-lane holding slot.

---
 rtl/softmax_pkg.sv | 20 ++
 rtl/lane_slot.sv | 62 ++++++
 rtl/exp_lane_scheduler.sv | 109 ++++++++++
 tb/tb_exp_lane_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Shared types and constants for the softmax exp stage.
// Lane states, default sample width and fixed-point formats.
package softmax_pkg;

  typedef enum logic [1:0] {
    LANE_FREE = 2'b00,
    LANE_BUSY = 2'b01,
    LANE_HELD = 2'b10
  } lane_state_e;

  localparam int DATA_W_DEFAULT    = 16;
  localparam int NUM_LANES_DEFAULT = 4;

  // Input is Q7.8 (signed, post max-subtract), output is Q0.16 (unsigned, e^x <= 1).
  localparam int Q_IN_INT   = 7;
  localparam int Q_IN_FRAC  = 8;
  localparam int Q_OUT_INT  = 0;
  localparam int Q_OUT_FRAC = 16;

endpackage

// File: rtl/lane_slot.sv
// Per-lane tracker: FREE/BUSY/HELD state, one-entry result slot, sticky capture error.
// Latency: a capture is visible one cycle later; lanes cannot be back-pressured, so the slot always accepts.
module lane_slot
  import softmax_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iIssue,
  input  logic              iCapValid,
  input  logic [DATA_W-1:0] iCapData,
  input  logic              iCapLast,
  input  logic              iDrain,
  output lane_state_e       oState,
  output logic [DATA_W-1:0] oData,
  output logic              oLast,
  output logic              oErr
);

  lane_state_e       r_state;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic              r_err;

  logic w_cap_ok;
  logic w_cap_bad;

  assign w_cap_ok  = iCapValid && (r_state == LANE_BUSY);
  assign w_cap_bad = iCapValid && (r_state != LANE_BUSY);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= LANE_FREE;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      // A strobe on a lane that is not waiting would overwrite a live or
      // undrained result; flag it and leave the slot untouched.
      if (w_cap_bad) begin
        r_err <= 1'b1;
      end
      if (w_cap_ok) begin
        r_data <= iCapData;
        r_last <= iCapLast;
      end
      case (r_state)
        LANE_FREE: if (iIssue)   r_state <= LANE_BUSY;
        LANE_BUSY: if (w_cap_ok) r_state <= LANE_HELD;
        LANE_HELD: if (iDrain)   r_state <= LANE_FREE;
        default:                 r_state <= LANE_FREE;
      endcase
    end
  end

  assign oState = r_state;
  assign oData  = r_data;
  assign oLast  = r_last;
  assign oErr   = r_err;

endmodule

// File: rtl/exp_lane_scheduler.sv
// Round-robin scheduler spreading a sample stream over NUM_LANES e^x lanes, results returned in input order.
// Latency: zero-cycle issue, lane latency + 1 to output; iReady=0 holds output, lanes keep completing into slots.
module exp_lane_scheduler
  import softmax_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEFAULT,
  parameter int DATA_W    = DATA_W_DEFAULT
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic                          iValid,
  output logic                          oReady,
  input  logic                          iLast,
  input  logic [DATA_W-1:0]             iData,
  output logic                          oValid,
  input  logic                          iReady,
  output logic                          oLast,
  output logic [DATA_W-1:0]             oData,
  output logic [NUM_LANES-1:0]          oLaneValid,
  input  logic [NUM_LANES-1:0]          iLaneReady,
  output logic [NUM_LANES-1:0]          oLaneLast,
  output logic [NUM_LANES*DATA_W-1:0]   oLaneData,
  input  logic [NUM_LANES-1:0]          iLaneValid,
  input  logic [NUM_LANES-1:0]          iLaneLast,
  input  logic [NUM_LANES*DATA_W-1:0]   iLaneData,
  output logic [NUM_LANES-1:0]          oLaneReady,
  output logic [$clog2(NUM_LANES):0]    oInFlight,
  output logic                          oErr
);

  localparam int PTR_W = $clog2(NUM_LANES);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_issue_ptr;
  logic [PTR_W-1:0] r_drain_ptr;
  logic [CNT_W-1:0] r_in_flight;

  lane_state_e       w_state     [NUM_LANES];
  logic [DATA_W-1:0] w_slot_data [NUM_LANES];
  logic [NUM_LANES-1:0] w_slot_last;
  logic [NUM_LANES-1:0] w_lane_err;
  logic [NUM_LANES-1:0] w_issue;
  logic [NUM_LANES-1:0] w_drain;

  logic w_issue_hs;
  logic w_drain_hs;

  // Issue only onto a registered-FREE lane, so a lane drained this cycle is
  // never re-issued until the next one.
  assign oReady     = (w_state[r_issue_ptr] == LANE_FREE) && iLaneReady[r_issue_ptr];
  assign w_issue_hs = iValid && oReady;

  assign oValid     = (w_state[r_drain_ptr] == LANE_HELD);
  assign oData      = w_slot_data[r_drain_ptr];
  assign oLast      = w_slot_last[r_drain_ptr];
  assign w_drain_hs = oValid && iReady;

  genvar k;
  generate
    for (k = 0; k < NUM_LANES; k++) begin : g_lane
      assign w_issue[k]                     = w_issue_hs && (r_issue_ptr == PTR_W'(k));
      assign w_drain[k]                     = w_drain_hs && (r_drain_ptr == PTR_W'(k));
      assign oLaneValid[k]                  = w_issue[k];
      assign oLaneLast[k]                   = iLast;
      assign oLaneData[k*DATA_W +: DATA_W]  = iData;

      lane_slot #(
        .DATA_W (DATA_W)
      ) u_slot (
        .iClk      (iClk),
        .iRst      (iRst),
        .iIssue    (w_issue[k]),
        .iCapValid (iLaneValid[k]),
        .iCapData  (iLaneData[k*DATA_W +: DATA_W]),
        .iCapLast  (iLaneLast[k]),
        .iDrain    (w_drain[k]),
        .oState    (w_state[k]),
        .oData     (w_slot_data[k]),
        .oLast     (w_slot_last[k]),
        .oErr      (w_lane_err[k])
      );
    end
  endgenerate

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_issue_ptr <= '0;
      r_drain_ptr <= '0;
      r_in_flight <= '0;
    end else begin
      if (w_issue_hs) begin
        r_issue_ptr <= r_issue_ptr + PTR_W'(1);
      end
      if (w_drain_hs) begin
        r_drain_ptr <= r_drain_ptr + PTR_W'(1);
      end
      case ({w_issue_hs, w_drain_hs})
        2'b10:   r_in_flight <= r_in_flight + CNT_W'(1);
        2'b01:   r_in_flight <= r_in_flight - CNT_W'(1);
        default: r_in_flight <= r_in_flight;
      endcase
    end
  end

  assign oLaneReady = '1;
  assign oInFlight  = r_in_flight;
  assign oErr       = |w_lane_err;

endmodule

// File: tb/tb_exp_lane_scheduler.sv
// Bench for exp_lane_scheduler: fixed-latency XOR lane models plus an in-order scoreboard.
module tb_exp_lane_scheduler;

  logic        iClk;
  logic        iRst;
  logic        iValid, oReady, iLast;
  logic [15:0] iData;
  logic        oValid, iReady, oLast;
  logic [15:0] oData;
  logic [3:0]  oLaneValid, iLaneReady, oLaneLast, iLaneValid, iLaneLast, oLaneReady;
  logic [63:0] oLaneData, iLaneData;
  logic [2:0]  oInFlight;
  logic        oErr;

  exp_lane_scheduler #(.NUM_LANES(4), .DATA_W(16)) dut (
    .iClk(iClk), .iRst(iRst),
    .iValid(iValid), .oReady(oReady), .iLast(iLast), .iData(iData),
    .oValid(oValid), .iReady(iReady), .oLast(oLast), .oData(oData),
    .oLaneValid(oLaneValid), .iLaneReady(iLaneReady), .oLaneLast(oLaneLast),
    .oLaneData(oLaneData), .iLaneValid(iLaneValid), .iLaneLast(iLaneLast),
    .iLaneData(iLaneData), .oLaneReady(oLaneReady), .oInFlight(oInFlight), .oErr(oErr)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  int          lat [4];
  logic [3:0]  inj;
  logic [3:0]  m_busy;
  int          m_cnt [4];
  logic [15:0] m_res [4];
  logic [3:0]  m_last;

  // Lane model: accepts only when idle, strobes data^FFFF for one cycle L cycles later.
  always @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      m_busy <= '0;
      for (int k = 0; k < 4; k++) m_cnt[k] <= 0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (m_busy[k]) begin
          if (m_cnt[k] == 0) m_busy[k] <= 1'b0;
          else m_cnt[k] <= m_cnt[k] - 1;
        end else if (oLaneValid[k]) begin
          m_busy[k] <= 1'b1;
          m_cnt[k]  <= lat[k] - 1;
          m_res[k]  <= oLaneData[k*16 +: 16] ^ 16'hFFFF;
          m_last[k] <= oLaneLast[k];
        end
      end
    end
  end

  always_comb begin
    iLaneReady = ~m_busy;
    iLaneValid = inj;
    iLaneLast  = '0;
    iLaneData  = '0;
    for (int k = 0; k < 4; k++) begin
      if (m_busy[k] && m_cnt[k] == 0) iLaneValid[k] = 1'b1;
      iLaneLast[k]         = m_last[k];
      iLaneData[k*16 +: 16] = m_res[k];
    end
  end

  logic [16:0] send_q [$];
  logic [16:0] exp_q  [$];
  logic        s_ihs, s_ohs, s_ov, s_ol;
  logic [15:0] s_od;
  logic [3:0]  s_lv;
  int          s_cyc;

  // One clock: drive from send_q, sample at negedge, push expectations on input handshake.
  task automatic tick();
    logic [16:0] t;
    if (!iRst && send_q.size() != 0) begin
      iValid = 1'b1; iData = send_q[0][15:0]; iLast = send_q[0][16];
    end else begin
      iValid = 1'b0; iData = '0; iLast = 1'b0;
    end
    @(negedge iClk);
    s_cyc = cyc;
    s_ihs = iValid && oReady;
    s_ohs = oValid && iReady;
    s_ov  = oValid; s_od = oData; s_ol = oLast; s_lv = oLaneValid;
    if (s_ihs) begin
      t = send_q.pop_front();
      exp_q.push_back({t[16], t[15:0] ^ 16'hFFFF});
    end
    @(posedge iClk); #1;
    cyc++;
  endtask

  task automatic test_reset();
    iRst = 1'b1; iReady = 1'b0; inj = '0;
    repeat (3) @(posedge iClk);
    #1;
    n_vec++; if (oValid !== 1'b0) begin n_err++; $display("FAIL rst_oValid: got %b want 0", oValid); end
    n_vec++; if (oData !== 16'h0) begin n_err++; $display("FAIL rst_oData: got %h want 0000", oData); end
    n_vec++; if (oInFlight !== 3'd0) begin n_err++; $display("FAIL rst_inflight: got %0d want 0", oInFlight); end
    n_vec++; if (oLaneValid !== 4'h0) begin n_err++; $display("FAIL rst_laneValid: got %b want 0000", oLaneValid); end
    iRst = 1'b0;
    @(posedge iClk); #1;
    n_vec++; if (oReady !== 1'b1) begin n_err++; $display("FAIL rst_oReady: got %b want 1", oReady); end
    n_vec++; if (oLast !== 1'b0) begin n_err++; $display("FAIL rst_oLast: got %b want 0", oLast); end
    n_vec++; if (oErr !== 1'b0) begin n_err++; $display("FAIL rst_oErr: got %b want 0", oErr); end
    n_vec++; if (oLaneReady !== 4'hF) begin n_err++; $display("FAIL rst_laneReady: got %b want 1111", oLaneReady); end
  endtask

  task automatic test_stream();
    logic [16:0] e;
    int issued = 0, beats = 0, first_in = -1, first_out = -1;
    lat = '{13, 13, 13, 13};
    iReady = 1'b1;
    for (int i = 0; i < 8; i++) send_q.push_back({1'b0, 16'(i)});
    for (int t = 0; t < 300 && beats < 8; t++) begin
      tick();
      if (s_ihs) begin
        issued++;
        if (first_in < 0) first_in = s_cyc;
        if (issued == 4) begin
          n_vec++; if (oReady !== 1'b0) begin n_err++; $display("FAIL stream_full_rdy: got %b want 0", oReady); end
        end
      end
      if (s_ov && first_out < 0) first_out = s_cyc;
      if (s_ohs) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL stream_extra: got %h want none", {s_ol, s_od}); end
        else begin
          e = exp_q.pop_front();
          if ({s_ol, s_od} !== e) begin n_err++; $display("FAIL stream_beat%0d: got %h want %h", beats, {s_ol, s_od}, e); end
        end
        beats++;
      end
    end
    n_vec++; if (beats != 8) begin n_err++; $display("FAIL stream_timeout: got %0d beats want 8", beats); end
    n_vec++; if (first_out - first_in != 14) begin n_err++; $display("FAIL stream_latency: got %0d want 14", first_out - first_in); end
    n_vec++; if (oInFlight !== 3'd0) begin n_err++; $display("FAIL stream_inflight_end: got %0d want 0", oInFlight); end
  endtask

  task automatic test_out_of_order();
    logic [16:0] e;
    int beats = 0, first_in = -1, first_out = -1;
    lat = '{20, 5, 13, 7};
    iReady = 1'b1;
    for (int i = 0; i < 4; i++) send_q.push_back({1'b0, 16'(16'h0010 + i)});
    for (int t = 0; t < 300 && beats < 4; t++) begin
      tick();
      if (s_ihs && first_in < 0) first_in = s_cyc;
      if (s_ov && first_out < 0) first_out = s_cyc;
      if (s_ohs) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL ooo_extra: got %h want none", {s_ol, s_od}); end
        else begin
          e = exp_q.pop_front();
          if ({s_ol, s_od} !== e) begin n_err++; $display("FAIL ooo_beat%0d: got %h want %h", beats, {s_ol, s_od}, e); end
        end
        beats++;
      end
    end
    n_vec++; if (beats != 4) begin n_err++; $display("FAIL ooo_timeout: got %0d beats want 4", beats); end
    n_vec++; if (first_out - first_in != 21) begin n_err++; $display("FAIL ooo_first_valid: got %0d want 21", first_out - first_in); end
  endtask

  task automatic test_stall();
    logic [16:0] e;
    logic        seen = 1'b0, changed = 1'b0;
    logic [15:0] held = '0;
    lat = '{13, 13, 13, 13};
    iReady = 1'b0;
    for (int i = 0; i < 4; i++) send_q.push_back({1'b0, 16'(i)});
    for (int t = 0; t < 40; t++) begin
      tick();
      if (s_ov) begin
        if (!seen) begin seen = 1'b1; held = s_od; end
        else if (s_od !== held) changed = 1'b1;
      end
    end
    n_vec++; if (oInFlight !== 3'd4) begin n_err++; $display("FAIL stall_inflight: got %0d want 4", oInFlight); end
    n_vec++; if (oReady !== 1'b0) begin n_err++; $display("FAIL stall_oReady: got %b want 0", oReady); end
    n_vec++; if (!seen || held !== 16'hFFFF) begin n_err++; $display("FAIL stall_hold_data: got %h seen %b want ffff", held, seen); end
    n_vec++; if (changed !== 1'b0) begin n_err++; $display("FAIL stall_stable: got changed=%b want 0", changed); end
    iReady = 1'b1;
    for (int b = 0; b < 4; b++) begin
      tick();
      n_vec++;
      if (!s_ohs) begin n_err++; $display("FAIL stall_release%0d: got no beat want beat", b); end
      else if (exp_q.size() == 0) begin n_err++; $display("FAIL stall_extra: got %h want none", {s_ol, s_od}); end
      else begin
        e = exp_q.pop_front();
        if ({s_ol, s_od} !== e) begin n_err++; $display("FAIL stall_beat%0d: got %h want %h", b, {s_ol, s_od}, e); end
      end
    end
    n_vec++; if (oInFlight !== 3'd0) begin n_err++; $display("FAIL stall_inflight_end: got %0d want 0", oInFlight); end
  endtask

  task automatic test_last();
    logic [16:0] e;
    int beats = 0;
    lat = '{13, 13, 13, 13};
    iReady = 1'b1;
    for (int i = 0; i < 4; i++) send_q.push_back({(i == 2), 16'(16'h00A0 + i)});
    for (int t = 0; t < 300 && beats < 4; t++) begin
      tick();
      if (s_ohs) begin
        n_vec++;
        if (s_ol !== (beats == 2)) begin n_err++; $display("FAIL last_beat%0d: got %b want %b", beats, s_ol, (beats == 2)); end
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL last_extra: got %h want none", {s_ol, s_od}); end
        else begin
          e = exp_q.pop_front();
          if ({s_ol, s_od} !== e) begin n_err++; $display("FAIL last_data%0d: got %h want %h", beats, {s_ol, s_od}, e); end
        end
        beats++;
      end
    end
    n_vec++; if (beats != 4) begin n_err++; $display("FAIL last_timeout: got %0d beats want 4", beats); end
  endtask

  task automatic test_err();
    logic [16:0] e;
    int beats = 0;
    n_vec++; if (oErr !== 1'b0) begin n_err++; $display("FAIL err_before: got %b want 0", oErr); end
    inj = 4'b0100;
    tick();
    inj = 4'b0000;
    n_vec++; if (oErr !== 1'b1) begin n_err++; $display("FAIL err_set: got %b want 1", oErr); end
    n_vec++; if (oValid !== 1'b0) begin n_err++; $display("FAIL err_no_output: got %b want 0", oValid); end
    lat = '{13, 13, 13, 13};
    iReady = 1'b1;
    for (int i = 0; i < 4; i++) send_q.push_back({1'b0, 16'(16'h1230 + i)});
    for (int t = 0; t < 300 && beats < 4; t++) begin
      tick();
      if (s_ohs) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL err_extra: got %h want none", {s_ol, s_od}); end
        else begin
          e = exp_q.pop_front();
          if ({s_ol, s_od} !== e) begin n_err++; $display("FAIL err_beat%0d: got %h want %h", beats, {s_ol, s_od}, e); end
        end
        beats++;
      end
    end
    n_vec++; if (beats != 4) begin n_err++; $display("FAIL err_timeout: got %0d beats want 4", beats); end
    n_vec++; if (oErr !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", oErr); end
  endtask

  task automatic test_reset_mid();
    logic [16:0] e;
    int beats = 0;
    logic first = 1'b1;
    lat = '{13, 40, 40, 40};
    iReady = 1'b0;
    for (int i = 0; i < 4; i++) send_q.push_back({1'b0, 16'(16'h0050 + i)});
    repeat (20) tick();
    n_vec++; if (oValid !== 1'b1) begin n_err++; $display("FAIL rmid_held: got %b want 1", oValid); end
    n_vec++; if (oInFlight !== 3'd4) begin n_err++; $display("FAIL rmid_inflight: got %0d want 4", oInFlight); end
    iRst = 1'b1;
    exp_q.delete();
    tick();
    n_vec++; if (oValid !== 1'b0) begin n_err++; $display("FAIL rmid_oValid: got %b want 0", oValid); end
    n_vec++; if (oInFlight !== 3'd0) begin n_err++; $display("FAIL rmid_inflight0: got %0d want 0", oInFlight); end
    n_vec++; if (oErr !== 1'b0) begin n_err++; $display("FAIL rmid_oErr: got %b want 0", oErr); end
    n_vec++; if ({oLast, oData} !== 17'h0) begin n_err++; $display("FAIL rmid_oData: got %h want 00000", {oLast, oData}); end
    n_vec++; if (oLaneValid !== 4'h0) begin n_err++; $display("FAIL rmid_laneValid: got %b want 0000", oLaneValid); end
    iRst = 1'b0;
    tick();
    lat = '{13, 13, 13, 13};
    iReady = 1'b1;
    for (int i = 0; i < 4; i++) send_q.push_back({1'b0, 16'(16'h0060 + i)});
    for (int t = 0; t < 300 && beats < 4; t++) begin
      tick();
      if (s_ihs && first) begin
        first = 1'b0;
        n_vec++; if (s_lv !== 4'b0001) begin n_err++; $display("FAIL rmid_restart_lane: got %b want 0001", s_lv); end
      end
      if (s_ohs) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL rmid_extra: got %h want none", {s_ol, s_od}); end
        else begin
          e = exp_q.pop_front();
          if ({s_ol, s_od} !== e) begin n_err++; $display("FAIL rmid_beat%0d: got %h want %h", beats, {s_ol, s_od}, e); end
        end
        beats++;
      end
    end
    n_vec++; if (beats != 4) begin n_err++; $display("FAIL rmid_timeout: got %0d beats want 4", beats); end
  endtask

  initial begin
    iRst = 1'b1; iValid = 1'b0; iData = '0; iLast = 1'b0; iReady = 1'b0; inj = '0;
    lat = '{13, 13, 13, 13};
    test_reset();
    test_stream();
    test_out_of_order();
    test_stall();
    test_last();
    test_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
